// File: rtl/prog_memory_pkg.sv
// rtl/prog_memory_pkg.sv - shared constants and loader state encoding for prog_memory
package prog_memory_pkg;

   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] IO_IN_ADDR_DEF  = 8'hFE;
   localparam logic [DATA_W-1:0] IO_OUT_ADDR_DEF = 8'hFF;
   localparam int                LOAD_LIMIT_DEF  = 254;

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } ld_state_t;

endpackage

// File: rtl/prog_loader_fsm.sv
// rtl/prog_loader_fsm.sv - boot-loader FSM: holds the CPU, streams bytes into memory from address 0
module prog_loader_fsm
   import prog_memory_pkg::*;
#(
   parameter int LOAD_LIMIT = LOAD_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_err,
   output logic              cpu_hold,
   output logic              ld_we,
   output logic [DATA_W-1:0] ptr,
   output logic              run
);

   ld_state_t         state, state_nx;
   logic [DATA_W-1:0] ptr_nx;
   logic              err_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_WAIT;
         ptr    <= '0;
         ld_err <= 1'b0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         ld_err <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      err_nx   = ld_err;
      ld_we    = 1'b0;
      ld_ready = 1'b0;
      cpu_hold = 1'b1;
      run      = 1'b0;
      case (state)
         ST_WAIT: begin
            if (ld_start) begin
               state_nx = ST_LOAD;
               ptr_nx   = '0;
               err_nx   = 1'b0;
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            // A restart wins over a byte offered in the same cycle.
            if (ld_start) begin
               ptr_nx = '0;
               err_nx = 1'b0;
            end else if (ld_valid) begin
               if (ptr < DATA_W'(LOAD_LIMIT)) begin
                  ld_we  = 1'b1;
                  ptr_nx = ptr + 1'b1;
               end else begin
                  err_nx = 1'b1;
               end
               if (ld_last) begin
                  state_nx = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            state_nx = ST_RUN;
         end
         ST_RUN: begin
            cpu_hold = 1'b0;
            run      = 1'b1;
            if (ld_start) begin
               state_nx = ST_LOAD;
               ptr_nx   = '0;
               err_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = ST_WAIT;
         end
      endcase
   end

endmodule

// File: rtl/prog_memory.sv
// rtl/prog_memory.sv - 256x8 program/data store with I/O ports and boot loader for the 8-bit CPU
module prog_memory
   import prog_memory_pkg::*;
#(
   parameter logic [DATA_W-1:0] IO_IN_ADDR  = IO_IN_ADDR_DEF,
   parameter logic [DATA_W-1:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
   parameter int                LOAD_LIMIT  = LOAD_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Mem_ADDR,
   input  logic [DATA_W-1:0] Mem_IN,
   input  logic              write,
   output logic [DATA_W-1:0] Mem_OUT,
   output logic              cpu_hold,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_err,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe
);

   logic [DATA_W-1:0] mem [256];
   logic              ld_we;
   logic [DATA_W-1:0] ptr;
   logic              run;
   logic              cpu_mem_we;
   logic              cpu_out_we;

   prog_loader_fsm #(
      .LOAD_LIMIT (LOAD_LIMIT)
   ) u_loader (
      .clk      (clk),
      .reset    (reset),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .ld_err   (ld_err),
      .cpu_hold (cpu_hold),
      .ld_we    (ld_we),
      .ptr      (ptr),
      .run      (run)
   );

   // CPU writes only count while the loader has released the processor.
   assign cpu_out_we = run && write && (Mem_ADDR == IO_OUT_ADDR);
   assign cpu_mem_we = run && write && (Mem_ADDR != IO_OUT_ADDR) && (Mem_ADDR != IO_IN_ADDR);

   // Array is deliberately left out of reset so a partial load survives.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem[ptr] <= ld_data;
      end else if (cpu_mem_we) begin
         mem[Mem_ADDR] <= Mem_IN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_port   <= '0;
         out_strobe <= 1'b0;
      end else begin
         out_strobe <= cpu_out_we;
         if (cpu_out_we) begin
            out_port <= Mem_IN;
         end
      end
   end

   always_comb begin
      if (Mem_ADDR == IO_IN_ADDR) begin
         Mem_OUT = in_port;
      end else if (Mem_ADDR == IO_OUT_ADDR) begin
         Mem_OUT = out_port;
      end else begin
         Mem_OUT = mem[Mem_ADDR];
      end
   end

endmodule

// File: doc/prog_memory.md
Name: prog_memory

Overview:
- Memory-side responder for the 8-bit processor's memory bus: services the processor's address, write-data and write-strobe signals.
- Returns read data combinationally from a 256x8 store.
- Maps two top addresses to I/O: an input port and an output port with a write strobe.
- Contains a boot-loader FSM that holds the processor in reset while a byte stream is written into program memory from address 0, then releases it.

Parameters:
- IO_IN_ADDR, 8'hFE, address whose reads return in_port. Writes to it are ignored.
- IO_OUT_ADDR, 8'hFF, address whose writes update out_port. Reads of it return the current out_port.
- LOAD_LIMIT, 254, number of loadable bytes (addresses 0..LOAD_LIMIT-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Mem_ADDR  in  8  processor address (registered in the processor).
- Mem_IN  in  8  processor write data.
- write  in  1  processor write strobe.
- Mem_OUT  out  8  read data to the processor.
- cpu_hold  out  1  drives the processor's reset input; 1 = processor held.
- ld_start  in  1  one-cycle pulse that begins a program load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  qualifies the final byte (sampled only with ld_valid&ld_ready).
- ld_ready  out  1  loader may present a byte.
- ld_err  out  1  sticky: a byte was offered beyond LOAD_LIMIT.
- in_port  in  8  external input.
- out_port  out  8  output register.
- out_strobe  out  1  one-cycle pulse on each out_port update.

Behaviour:
- Reset values: state=WAIT, cpu_hold=1, ld_ready=0, ld_err=0, out_port=0, out_strobe=0, load pointer=0. Memory array contents are NOT cleared by reset.
- Read path (combinational, zero latency):
  - Mem_ADDR==IO_IN_ADDR -> Mem_OUT=in_port.
  - Mem_ADDR==IO_OUT_ADDR -> Mem_OUT=out_port.
  - Otherwise Mem_OUT=MEM[Mem_ADDR].
- States:
  - WAIT: cpu_hold=1, ld_ready=0. ld_start -> LOAD with ptr=0, ld_err cleared.
  - LOAD: cpu_hold=1, ld_ready=1.
    - Each cycle with ld_valid: if ptr<LOAD_LIMIT, write MEM[ptr]=ld_data at posedge and increment ptr; else drop the byte, set ld_err, hold ptr.
    - ld_valid&ld_last -> RELEASE (the last byte is written under the same rule).
    - ld_start in LOAD restarts: ptr=0, ld_err cleared, any simultaneous byte dropped.
  - RELEASE: one cycle, cpu_hold=1, ld_ready=0 -> RUN. This guarantees the processor sees reset through the final write.
  - RUN: cpu_hold=0, ld_ready=0.
    - write=1 at posedge: if Mem_ADDR==IO_OUT_ADDR, out_port<=Mem_IN and out_strobe=1 next cycle. If Mem_ADDR==IO_IN_ADDR, ignore. Otherwise MEM[Mem_ADDR]<=Mem_IN.
    - ld_start -> LOAD (reprogram): ptr=0, cpu_hold asserts the next cycle.
- Processor writes are honoured only in RUN. In other states write is ignored, so there is never a simultaneous CPU/loader write.
- Writes take effect at the posedge. A read of the same address in the following cycle returns the new value.
- out_strobe is a single-cycle pulse. Back-to-back writes to IO_OUT_ADDR give back-to-back pulses.
- ptr is 8-bit and never wraps: it saturates at LOAD_LIMIT.
- Reset mid-load or mid-run: immediate return to WAIT, cpu_hold=1. Partially loaded bytes remain in memory.
- A load with zero bytes is not possible: ld_last is only seen with a byte.

Decomposition:
- Shared package: state encoding (WAIT, LOAD, RELEASE, RUN), the I/O address constants, and the bus width 8.
- One natural sub-module: prog_loader_fsm (state, ptr, ld_ready, ld_err, cpu_hold). The array and I/O decode stay in the top.

Test Plan:
- Reset -> cpu_hold=1, out_port=0, ld_ready=0. Pulse ld_start -> ld_ready=1 next cycle.
- Load 3 bytes 8'h2D, 8'h14, 8'hFF (ld_last on the third) -> MEM[0..2] holds them, RELEASE for one cycle, cpu_hold=0 two cycles after the last handshake. Mem_ADDR=1 reads 8'h14.
- In RUN: write=1, Mem_ADDR=8'hFF, Mem_IN=8'hA5 -> out_port=8'hA5 and a one-cycle out_strobe. Mem_ADDR=8'hFF then reads 8'hA5.
- in_port=8'h3C, Mem_ADDR=8'hFE -> Mem_OUT=8'h3C same cycle. Write 8'h00 to 8'hFE -> Mem_OUT still 8'h3C, no strobe.
- Offer 255 bytes -> bytes 0..253 stored, 255th dropped, ld_err=1. A new ld_start clears ld_err.
- Assert reset during LOAD after 2 bytes -> state WAIT, cpu_hold=1, MEM[0..1] retained. Write in WAIT with write=1 to address 5 -> MEM[5] unchanged.
